// File: rtl/mem_loader_pkg.sv
// Shared definitions for the program-memory loader: FSM state encoding and default sizing.
package mem_loader_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEB_CYCLES = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_RD1   = 3'd3,
        S_RD2   = 3'd4,
        S_INC   = 3'd5
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Step-button conditioner: 2-flop synchronizer plus a down-counting debouncer that
// emits a single-clock pulse when a new pressed (low) level is accepted.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_N,
    input  logic btn_N,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Counter only runs while the synchronized input disagrees with the accepted level;
    // any agreeing sample restarts the stability window.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= RELOAD;
            press <= 1'b0;
        end else begin
            sync1 <= btn_N;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync2;
                cnt   <= RELOAD;
                press <= ~sync2;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Front-panel program-memory loader: address load, write with read-back, and browse.
// Define MEM_LOADER_VERIFY_EN to build the write read-back comparator and sticky verr flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a debounced press
// S_LOAD  | address just loaded from sw_code
// S_WRITE | pr_wr_en asserted for one clock at pr_adrs
// S_RD1   | address presented for read, memory access in flight
// S_RD2   | capture mm_data into rd_data; after a write go on to S_INC
// S_INC   | advance pr_adrs (wraps modulo depth)
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic              clock,
    input  logic              reset_N,
    input  logic              step_btn_N,
    input  logic              wr_sel,
    input  logic              adrs_ld,
    input  logic [DATA_W-1:0] sw_code,
    input  logic [DATA_W-1:0] mm_data,
    output logic [ADDR_W-1:0] pr_adrs,
    output logic [DATA_W-1:0] pr_code,
    output logic              pr_wr_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              verr
);

    state_t            state;
    state_t            next_state;
    logic              press;
    logic              wr_flag;
    logic [ADDR_W-1:0] load_adrs;
    logic              idle_press;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clock  (clock),
        .reset_N(reset_N),
        .btn_N  (step_btn_N),
        .press  (press)
    );

    generate
        if (ADDR_W <= DATA_W) begin : g_adrs_trunc
            assign load_adrs = sw_code[ADDR_W-1:0];
        end else begin : g_adrs_ext
            assign load_adrs = {{(ADDR_W - DATA_W){1'b0}}, sw_code};
        end
    endgenerate

    // Presses outside IDLE are simply ignored, which drops them rather than queueing.
    assign idle_press = (state == S_IDLE) && press;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (press) begin
                    if (adrs_ld) begin
                        next_state = S_LOAD;
                    end else if (wr_sel) begin
                        next_state = S_WRITE;
                    end else begin
                        next_state = S_INC;
                    end
                end
            end
            S_LOAD:  next_state = S_RD1;
            S_WRITE: next_state = S_RD1;
            S_RD1:   next_state = S_RD2;
            S_RD2:   next_state = wr_flag ? S_INC : S_IDLE;
            S_INC:   next_state = S_RD1;
            default: next_state = S_IDLE;
        endcase
    end

    // Strobe decoded from the async-reset state register, so reset drops it immediately.
    assign pr_wr_en = (state == S_WRITE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            pr_adrs <= '0;
            pr_code <= '0;
            rd_data <= '0;
            wr_flag <= 1'b0;
        end else begin
            if (idle_press) begin
                if (adrs_ld) begin
                    pr_adrs <= load_adrs;
                end else if (wr_sel) begin
                    pr_code <= sw_code;
                    wr_flag <= 1'b1;
                end
            end
            if (state == S_RD2) begin
                rd_data <= mm_data;
                wr_flag <= 1'b0;
            end
            if (state == S_INC) begin
                pr_adrs <= pr_adrs + 1'b1;
            end
        end
    end

`ifdef MEM_LOADER_VERIFY_EN
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            verr <= 1'b0;
        end else if (idle_press && adrs_ld) begin
            verr <= 1'b0;
        end else if ((state == S_RD2) && wr_flag && (mm_data != pr_code)) begin
            verr <= 1'b1;
        end
    end
`else
    assign verr = 1'b0;
`endif

endmodule
